// File: rtl/xmt_usb.sv
// Full-speed USB packet transmitter: SYNC, PID, token/data body, CRC5/CRC16 and EOP, with bit stuffing and NRZI.
// Optional XMT_USB_LOW_SPEED_EN: low-speed polarity (J = dp0/dm1) and a fixed 40-clock bit period.
module xmt_usb #(
  parameter int BIT_CYCLES = 5
) (
  input  logic        clk60,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  pid,
  input  logic [6:0]  addr,
  input  logic [3:0]  end_pt,
  input  logic [63:0] data_in,
  input  logic [3:0]  data_len,
  output logic        dp_out,
  output logic        dm_out,
  output logic        oe,
  output logic        busy,
  output logic        done
);

`ifdef XMT_USB_LOW_SPEED_EN
  localparam int         L_BC = 40;
  localparam logic [1:0] L_J  = 2'b01;
`else
  localparam int         L_BC = BIT_CYCLES;
  localparam logic [1:0] L_J  = 2'b10;
`endif
  localparam logic [1:0]    L_K    = ~L_J;
  localparam logic [1:0]    L_SE0  = 2'b00;
  localparam int            CW     = (L_BC > 2) ? $clog2(L_BC) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(L_BC - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_PID  = 3'd2;
  localparam logic [2:0] S_BODY = 3'd3;
  localparam logic [2:0] S_CRC  = 3'd4;
  localparam logic [2:0] S_EOP  = 3'd5;

  logic [2:0]    r_state;
  logic [6:0]    r_idx;
  logic [CW-1:0] r_cyc;
  logic [2:0]    r_ones;
  logic [1:0]    r_line;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_pid;
  logic [6:0]    r_addr;
  logic [3:0]    r_ep;
  logic [63:0]   r_data;
  logic [3:0]    r_len;
  logic [4:0]    r_crc5;
  logic [15:0]   r_crc16;

  logic          w_token;
  logic          w_hs;
  logic [7:0]    w_pid_byte;
  logic [15:0]   w_tok_body;
  logic [6:0]    w_body_last;
  logic          w_bit;
  logic          w_last;
  logic [2:0]    w_nxt_state;

  assign w_token     = (r_pid[1:0] == 2'b01);
  assign w_hs        = ~r_pid[0];
  assign w_pid_byte  = {~r_pid, r_pid};
  assign w_tok_body  = {5'b00000, r_ep, r_addr};
  assign w_body_last = w_token ? 7'd10 : ({r_len, 3'b000} - 7'd1);

  // (r_state, r_idx) always names the next bit to go on the line
  always_comb begin
    w_bit       = 1'b0;
    w_last      = 1'b0;
    w_nxt_state = r_state;
    case (r_state)
      S_SYNC: begin
        w_bit       = (r_idx[2:0] == 3'd7);
        w_last      = (r_idx[2:0] == 3'd7);
        w_nxt_state = S_PID;
      end
      S_PID: begin
        w_bit  = w_pid_byte[r_idx[2:0]];
        w_last = (r_idx[2:0] == 3'd7);
        if (w_hs)
          w_nxt_state = S_EOP;
        else if (!w_token && r_len == 4'd0)
          w_nxt_state = S_CRC;
        else
          w_nxt_state = S_BODY;
      end
      S_BODY: begin
        w_bit       = w_token ? w_tok_body[r_idx[3:0]] : r_data[r_idx[5:0]];
        w_last      = (r_idx == w_body_last);
        w_nxt_state = S_CRC;
      end
      S_CRC: begin
        w_bit       = w_token ? ~r_crc5[3'd4 - r_idx[2:0]] : ~r_crc16[4'd15 - r_idx[3:0]];
        w_last      = w_token ? (r_idx == 7'd4) : (r_idx == 7'd15);
        w_nxt_state = S_EOP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk60 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cyc   <= '0;
      r_ones  <= '0;
      r_line  <= L_J;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pid   <= '0;
      r_addr  <= '0;
      r_ep    <= '0;
      r_data  <= '0;
      r_len   <= '0;
      r_crc5  <= 5'h1F;
      r_crc16 <= 16'hFFFF;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        // the cycle carrying done never accepts, so back-to-back starts need one idle cycle
        if (start && !r_done) begin
          r_pid   <= pid;
          r_addr  <= addr;
          r_ep    <= end_pt;
          r_data  <= data_in;
          r_len   <= (data_len > 4'd8) ? 4'd8 : data_len;
          r_busy  <= 1'b1;
          r_line  <= L_K;
          r_state <= S_SYNC;
          r_idx   <= 7'd1;
          r_cyc   <= '0;
          r_ones  <= '0;
          r_crc5  <= 5'h1F;
          r_crc16 <= 16'hFFFF;
        end
      end else if (r_cyc != L_LAST) begin
        r_cyc <= r_cyc + CW'(1);
      end else begin
        r_cyc <= '0;
        if (r_ones == 3'd6) begin
          r_line <= ~r_line;
          r_ones <= '0;
        end else if (r_state == S_EOP) begin
          r_idx <= r_idx + 7'd1;
          case (r_idx[1:0])
            2'd0, 2'd1: r_line <= L_SE0;
            2'd2:       r_line <= L_J;
            default: begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          endcase
        end else begin
          if (!w_bit)
            r_line <= ~r_line;
          r_ones <= w_bit ? (r_ones + 3'd1) : 3'd0;
          if (r_state == S_BODY) begin
            r_crc5  <= {r_crc5[3:0], 1'b0} ^ ((r_crc5[4] ^ w_bit) ? 5'h05 : 5'h00);
            r_crc16 <= {r_crc16[14:0], 1'b0} ^ ((r_crc16[15] ^ w_bit) ? 16'h8005 : 16'h0000);
          end
          if (w_last) begin
            r_state <= w_nxt_state;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 7'd1;
          end
        end
      end
    end
  end

  assign dp_out = r_line[1];
  assign dm_out = r_line[0];
  assign oe     = r_busy;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_xmt_usb.sv
// Directed bench for xmt_usb: a line sampler plus NRZI/destuff decoder check each packet against hand-computed values.
module tb_xmt_usb;
  localparam int BC = 5;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic        clk60 = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  end_pt;
  logic [63:0] data_in;
  logic [3:0]  data_len;
  logic        dp_out;
  logic        dm_out;
  logic        oe;
  logic        busy;
  logic        done;

  xmt_usb #(.BIT_CYCLES(BC)) dut (
    .clk60(clk60), .rst_n(rst_n), .start(start), .pid(pid), .addr(addr),
    .end_pt(end_pt), .data_in(data_in), .data_len(data_len),
    .dp_out(dp_out), .dm_out(dm_out), .oe(oe), .busy(busy), .done(done)
  );

  initial forever #5 clk60 = ~clk60;

  int nvec = 0;
  int nerr = 0;

  // line monitor: one sample per bit, mid-bit
  logic [1:0] q_line[$];
  int         oe_cnt;
  int         done_cnt;
  int         glitch_cnt;
  int         mon_cyc;
  logic [1:0] prev_line;

  always @(negedge clk60) begin
    if (done) done_cnt++;
    if (oe) begin
      if ((mon_cyc % BC) != 0 && {dp_out, dm_out} != prev_line) glitch_cnt++;
      if ((mon_cyc % BC) == 2) q_line.push_back({dp_out, dm_out});
      mon_cyc++;
      oe_cnt++;
    end
    prev_line = {dp_out, dm_out};
  end

  logic bits[$];
  int   nstuff;
  int   bad_stuff;
  int   n_pre;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    q_line.delete();
    oe_cnt = 0; done_cnt = 0; glitch_cnt = 0; mon_cyc = 0;
  endtask

  task automatic launch(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                        input logic [63:0] d, input logic [3:0] l);
    @(posedge clk60); #1;
    clear_mon();
    pid = p; addr = a; end_pt = e; data_in = d; data_len = l; start = 1'b1;
    @(posedge clk60); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk60); #1;
      n++;
    end
    chk({nm, ".timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic settle();
    repeat (2) begin
      @(posedge clk60); #1;
    end
  endtask

  // receiver view: NRZI decode, drop stuffed zeros, stop at SE0
  task automatic decode();
    logic [1:0] prv;
    int ones;
    logic b;
    bits.delete();
    nstuff = 0; bad_stuff = 0; n_pre = 0; prv = J; ones = 0;
    for (int i = 0; i < q_line.size(); i++) begin
      if (q_line[i] == SE0) break;
      b = (q_line[i] == prv);
      prv = q_line[i];
      n_pre++;
      if (ones == 6) begin
        nstuff++;
        ones = 0;
        if (b) bad_stuff++;
      end else begin
        bits.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
  endtask

  function automatic logic [7:0] get_byte(input int k);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++)
      if (8 * k + i < bits.size()) v[i] = bits[8 * k + i];
    return v;
  endfunction

  function automatic logic [4:0] res5();
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 16; i < bits.size(); i++)
      c = (c[4] ^ bits[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
    return c;
  endfunction

  function automatic logic [15:0] res16();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 16; i < bits.size(); i++)
      c = (c[15] ^ bits[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    return c;
  endfunction

  task automatic common(input string nm, input int exp_bits, input int exp_oe);
    logic eop_ok;
    eop_ok = (q_line.size() == n_pre + 3);
    if (eop_ok) eop_ok = (q_line[n_pre] == SE0) && (q_line[n_pre + 1] == SE0) && (q_line[n_pre + 2] == J);
    chk({nm, ".eop"}, 64'(eop_ok), 64'd1);
    chk({nm, ".oe_clocks"}, 64'(oe_cnt), 64'(exp_oe));
    chk({nm, ".bit_stable"}, 64'(glitch_cnt), 64'd0);
    chk({nm, ".nbits"}, 64'(bits.size()), 64'(exp_bits));
    chk({nm, ".sync"}, 64'(get_byte(0)), 64'h80);
  endtask

  initial begin
    logic [37:0] raw;
    logic [63:0] pl;

    rst_n = 1'b0; start = 1'b0; pid = '0; addr = '0; end_pt = '0; data_in = '0; data_len = '0;
    clear_mon();
    repeat (3) @(posedge clk60);
    #1;
    chk("reset.outs", 64'({dp_out, dm_out, oe, busy, done}), 64'(5'b10000));
    rst_n = 1'b1;
    repeat (2) @(posedge clk60);
    #1;
    chk("idle.outs", 64'({dp_out, dm_out, oe, busy, done}), 64'(5'b10000));

    // ACK handshake
    launch(4'h2, 7'd0, 4'd0, 64'd0, 4'd0);
    chk("ack.accept", 64'({dp_out, dm_out, oe, busy}), 64'({K, 2'b11}));
    wait_idle("ack");
    chk("ack.done_edge", 64'({oe, busy, done}), 64'(3'b001));
    settle();
    decode();
    common("ack", 16, 95);
    chk("ack.done_cnt", 64'(done_cnt), 64'd1);
    chk("ack.pid", 64'(get_byte(1)), 64'hD2);
    chk("ack.nstuff", 64'(nstuff), 64'd0);
    raw = '0;
    for (int i = 0; i < 19; i++) raw = {raw[35:0], (i < q_line.size()) ? q_line[i] : 2'bxx};
    chk("ack.line_seq", 64'(raw), 64'({K, J, K, J, K, J, K, K, J, J, K, J, J, K, K, K, SE0, SE0, J}));

    // IN token to address 0 endpoint 0
    launch(4'h9, 7'd0, 4'd0, 64'd0, 4'd0);
    wait_idle("in");
    settle();
    decode();
    common("in", 32, 175);
    chk("in.done_cnt", 64'(done_cnt), 64'd1);
    chk("in.bytes", 64'({get_byte(1), get_byte(2), get_byte(3)}), 64'h690010);
    chk("in.crc5_residual", 64'(res5()), 64'(5'b01100));

    // zero-length DATA1
    launch(4'hB, 7'd0, 4'd0, 64'd0, 4'd0);
    wait_idle("zld");
    settle();
    decode();
    common("zld", 32, 175);
    chk("zld.done_cnt", 64'(done_cnt), 64'd1);
    chk("zld.bytes", 64'({get_byte(1), get_byte(2), get_byte(3)}), 64'h4B0000);

    // DATA0 with one 0xFF byte: stuff after 4th payload bit and inside the CRC
    launch(4'h3, 7'd0, 4'd0, 64'h00000000000000FF, 4'd1);
    wait_idle("stuff");
    settle();
    decode();
    common("stuff", 40, 225);
    chk("stuff.bytes", 64'({get_byte(1), get_byte(2), get_byte(3), get_byte(4)}), 64'hC3FF00FF);
    chk("stuff.nstuff", 64'(nstuff), 64'd2);
    chk("stuff.stuff_is_zero", 64'(bad_stuff), 64'd0);
    chk("stuff.crc16_residual", 64'(res16()), 64'h800D);
    chk("stuff.line_16_19_20_21", 64'({q_line[16], q_line[19], q_line[20], q_line[21]}), 64'({K, K, J, J}));

    // length clamp, mid-packet start and input changes ignored
    launch(4'h3, 7'd0, 4'd0, 64'hEFCDAB8967452301, 4'hC);
    repeat (100) @(posedge clk60);
    #1;
    start = 1'b1; pid = 4'h2; data_in = 64'h0; data_len = 4'd1;
    @(posedge clk60); #1;
    start = 1'b0;
    chk("clamp.busy_after_poke", 64'(busy), 64'd1);
    wait_idle("clamp");
    chk("clamp.done", 64'(done), 64'd1);
    decode();
    common("clamp", 96, (96 + nstuff + 3) * BC);
    chk("clamp.pid", 64'(get_byte(1)), 64'hC3);
    pl = '0;
    for (int k = 0; k < 8; k++) pl[8 * k +: 8] = get_byte(2 + k);
    chk("clamp.payload", pl, 64'hEFCDAB8967452301);
    chk("clamp.crc16_residual", 64'(res16()), 64'h800D);

    // back-to-back: start during done is dropped, one cycle later is taken
    pid = 4'h2; data_len = 4'd0; start = 1'b1;
    @(posedge clk60); #1;
    chk("b2b.same_cycle_ignored", 64'(busy), 64'd0);
    clear_mon();
    @(posedge clk60); #1;
    start = 1'b0;
    chk("b2b.next_cycle_taken", 64'({dp_out, dm_out, oe, busy}), 64'({K, 2'b11}));
    wait_idle("b2b");
    settle();
    decode();
    common("b2b", 16, 95);
    chk("b2b.done_cnt", 64'(done_cnt), 64'd1);

    // reset during BODY
    launch(4'h3, 7'd0, 4'd0, 64'h5555, 4'd2);
    repeat (90) @(posedge clk60);
    #1;
    chk("rst.busy_before", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.async_outs", 64'({dp_out, dm_out, oe, busy, done}), 64'(5'b10000));
    repeat (3) @(posedge clk60);
    #1;
    chk("rst.held_outs", 64'({dp_out, dm_out, oe, busy, done}), 64'(5'b10000));
    chk("rst.no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;

    launch(4'h2, 7'd0, 4'd0, 64'd0, 4'd0);
    wait_idle("post_rst");
    settle();
    decode();
    common("post_rst", 16, 95);
    chk("post_rst.pid", 64'(get_byte(1)), 64'hD2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
